arm_regfile_pc: RTL and testbench

//  Parametrised successor to the ARM datapath register file: NUM_REGS x DATA_W storage,

---
 rtl/arm_regfile_pc.sv | 163 ++++++++++++++++
 tb/tb_arm_regfile_pc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_regfile_pc.sv
`default_nettype none
// ============================================================================
//  Module   : arm_regfile_pc
//  Purpose  : Parametrised ARM-style register file. NUM_REGS x DATA_W storage
//             with three read ports (A, B, D) and one write port (C). The top
//             register is the program counter: it auto-increments by PC_STEP
//             and is seen by the read ports with a PC_RD_OFS pipeline offset.
//             Optional write-through bypass and optional registered reads.
//  Ports    : clk    in   1       clock, rising edge
//             reset  in   1       asynchronous reset, active low
//             we     in   1       write enable, port C
//             wa     in   ADDR_W  write address
//             wd     in   DATA_W  write data
//             a/b/d  in   ADDR_W  read addresses, ports A/B/D
//             pc_inc in   1       advance the PC by PC_STEP this cycle
//             pa/pb/pd out DATA_W read data, ports A/B/D
//             pc_out out  DATA_W  raw stored PC (fetch address, no offset)
//  Revision : 1.0  initial release
// ============================================================================
module arm_regfile_pc #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned PC_STEP   = 4,
    parameter int unsigned PC_RD_OFS = 8,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned READ_REG  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] wa,
    input  logic [DATA_W-1:0]           wd,
    input  logic [$clog2(NUM_REGS)-1:0] a,
    input  logic [$clog2(NUM_REGS)-1:0] b,
    input  logic [$clog2(NUM_REGS)-1:0] d,
    input  logic                        pc_inc,
    output logic [DATA_W-1:0]           pa,
    output logic [DATA_W-1:0]           pb,
    output logic [DATA_W-1:0]           pd,
    output logic [DATA_W-1:0]           pc_out
);

    localparam int unsigned       ADDR_W      = $clog2(NUM_REGS);
    localparam int unsigned       ADDR_SPAN   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_pc_idx    = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] c_reset_pc  = DATA_W'(RESET_PC);
    localparam logic [DATA_W-1:0] c_pc_step   = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] c_rd_ofs    = DATA_W'(PC_RD_OFS);

    // General-purpose registers R0..R(NUM_REGS-2); the PC is held separately.
    logic [DATA_W-1:0] r_regs [0:NUM_REGS-2];
    logic [DATA_W-1:0] r_pc;

    logic              w_pc_wr;
    logic [DATA_W-1:0] w_pc_src;

    // Read view of the whole address space, bypass and PC offset already
    // applied. Sized to the full address span so that out-of-range
    // addresses simply index a zero entry.
    logic [DATA_W-1:0] w_view [0:ADDR_SPAN-1];
    logic [ADDR_W-1:0] w_addr [0:2];
    logic [DATA_W-1:0] w_rv   [0:2];

    // ------------------------------------------------------------------
    // General-purpose register writes. Addresses at or above the PC index
    // never match here, so out-of-range writes have no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
                if (we && (wa == ADDR_W'(i))) begin
                    r_regs[i] <= wd;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Program counter: an explicit write takes priority over increment.
    // ------------------------------------------------------------------
    assign w_pc_wr = we && (wa == c_pc_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= c_reset_pc;
        end else if (w_pc_wr) begin
            r_pc <= wd;
        end else if (pc_inc) begin
            r_pc <= r_pc + c_pc_step;
        end
    end

    assign pc_out = r_pc;

    // ------------------------------------------------------------------
    // Read view construction
    // ------------------------------------------------------------------
    assign w_pc_src = ((BYPASS != 0) && w_pc_wr) ? wd : r_pc;

    genvar gi;
    generate
        for (gi = 0; gi < int'(ADDR_SPAN); gi++) begin : g_view
            if (gi < int'(NUM_REGS) - 1) begin : g_gpr
                assign w_view[gi] = ((BYPASS != 0) && we && (wa == ADDR_W'(gi)))
                                    ? wd : r_regs[gi];
            end else if (gi == int'(NUM_REGS) - 1) begin : g_pc
                // ARM pipeline view: reads of the PC see it PC_RD_OFS ahead.
                assign w_view[gi] = w_pc_src + c_rd_ofs;
            end else begin : g_unmapped
                assign w_view[gi] = '0;
            end
        end
    endgenerate

    assign w_addr[0] = a;
    assign w_addr[1] = b;
    assign w_addr[2] = d;

    genvar gp;
    generate
        for (gp = 0; gp < 3; gp++) begin : g_port
            assign w_rv[gp] = w_view[w_addr[gp]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: registered (one-cycle latency) or combinational.
    // ------------------------------------------------------------------
    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] r_pa;
            logic [DATA_W-1:0] r_pb;
            logic [DATA_W-1:0] r_pd;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pa <= '0;
                    r_pb <= '0;
                    r_pd <= '0;
                end else begin
                    r_pa <= w_rv[0];
                    r_pb <= w_rv[1];
                    r_pd <= w_rv[2];
                end
            end

            assign pa = r_pa;
            assign pb = r_pb;
            assign pd = r_pd;
        end else begin : g_rd_comb
            assign pa = w_rv[0];
            assign pb = w_rv[1];
            assign pd = w_rv[2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arm_regfile_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_regfile_pc
//  Purpose  : Self-checking bench for arm_regfile_pc. Three configurations
//             share one stimulus stream:
//               dut0  defaults (32-bit, 16 regs, bypass, combinational reads)
//               dut1  no bypass, registered reads
//               dut2  16-bit, 12 regs (PC = R11), bypass, combinational reads
//             A behavioural model holds each configuration's register
//             contents as plain arrays and applies the read/write rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arm_regfile_pc;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic        pc_inc;

    logic [31:0] pa0, pb0, pd0, pc0;
    logic [31:0] pa1, pb1, pd1, pc1;
    logic [15:0] pa2, pb2, pd2, pc2;

    int total = 0;
    int bad   = 0;

    // Per-configuration model parameters
    int          nr   [0:2] = '{16, 16, 12};
    logic [31:0] mask [0:2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    int          byp  [0:2] = '{1, 0, 1};
    int          rr   [0:2] = '{0, 1, 0};

    // Model state
    logic [31:0] m_reg [0:2][0:15];
    logic [31:0] m_rd  [0:2][0:2];

    arm_regfile_pc dut0 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .a(a), .b(b), .d(d), .pc_inc(pc_inc),
        .pa(pa0), .pb(pb0), .pd(pd0), .pc_out(pc0)
    );

    arm_regfile_pc #(.BYPASS(0), .READ_REG(1)) dut1 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .a(a), .b(b), .d(d), .pc_inc(pc_inc),
        .pa(pa1), .pb(pb1), .pd(pd1), .pc_out(pc1)
    );

    arm_regfile_pc #(.DATA_W(16), .NUM_REGS(12)) dut2 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd[15:0]),
        .a(a), .b(b), .d(d), .pc_inc(pc_inc),
        .pa(pa2), .pb(pb2), .pd(pd2), .pc_out(pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- model
    function automatic int addr_of(int p);
        if (p == 0) return int'(a);
        if (p == 1) return int'(b);
        return int'(d);
    endfunction

    function automatic logic [31:0] rv(int k, int x);
        logic [31:0] v;
        if (x >= nr[k]) return 32'h0;
        v = m_reg[k][x];
        if (byp[k] != 0 && we && int'(wa) == x) v = wd & mask[k];
        if (x == nr[k] - 1) v = (v + 32'd8) & mask[k];
        return v;
    endfunction

    function automatic logic [31:0] act(int k, int p);
        case (k)
            0: case (p) 0: return pa0; 1: return pb0; 2: return pd0; default: return pc0; endcase
            1: case (p) 0: return pa1; 1: return pb1; 2: return pd1; default: return pc1; endcase
            default: case (p)
                0: return {16'h0, pa2}; 1: return {16'h0, pb2};
                2: return {16'h0, pd2}; default: return {16'h0, pc2};
            endcase
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) m_reg[k][i] = 32'h0;
            for (int p = 0; p < 3; p++) m_rd[k][p] = 32'h0;
        end
    endtask

    // Effect of one rising edge with the current inputs.
    task automatic model_edge();
        int pcx;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 3; p++) m_rd[k][p] = rv(k, addr_of(p));
            pcx = nr[k] - 1;
            if (we && int'(wa) < nr[k]) begin
                m_reg[k][int'(wa)] = wd & mask[k];
            end else if (pc_inc) begin
                m_reg[k][pcx] = (m_reg[k][pcx] + 32'd4) & mask[k];
            end
            if (we && int'(wa) < pcx && pc_inc) begin
                m_reg[k][pcx] = (m_reg[k][pcx] + 32'd4) & mask[k];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 3; p++) begin
                e = (rr[k] != 0) ? m_rd[k][p] : rv(k, addr_of(p));
                chk($sformatf("%s dut%0d port%0d", tag, k, p), act(k, p), e);
            end
            chk($sformatf("%s dut%0d pc_out", tag, k), act(k, 3), m_reg[k][nr[k] - 1]);
        end
    endtask

    // Drive one cycle: inputs set just after an edge, checked mid-cycle
    // (at the falling edge), then the model advances on the rising edge.
    task automatic apply(input logic iwe, input logic [3:0] iwa, input logic [31:0] iwd,
                         input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] id,
                         input logic iinc, input string tag);
        we = iwe; wa = iwa; wd = iwd; a = ia; b = ib; d = id; pc_inc = iinc;
        #4;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  a;
        logic        inc;
        logic [31:0] exp_pa;   // dut0 port A, before the edge
        logic [31:0] exp_pc;   // dut0 pc_out, before the edge
    } vec_t;

    vec_t tbl [0:18];

    initial begin
        tbl[0]  = '{1'b1, 4'd5,  32'hDEAD_BEEF, 4'd5,  1'b0, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b0, 4'd0,  32'h0,         4'd5,  1'b0, 32'hDEAD_BEEF, 32'h0};
        tbl[2]  = '{1'b1, 4'd7,  32'h0000_1234, 4'd7,  1'b0, 32'h0000_1234, 32'h0};
        tbl[3]  = '{1'b0, 4'd0,  32'h0,         4'd7,  1'b1, 32'h0000_1234, 32'h0};
        tbl[4]  = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b1, 32'd12,        32'd4};
        tbl[5]  = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b1, 32'd16,        32'd8};
        tbl[6]  = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b0, 32'd20,        32'd12};
        tbl[7]  = '{1'b1, 4'd15, 32'h0000_0100, 4'd15, 1'b1, 32'h0000_0108, 32'd12};
        tbl[8]  = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b0, 32'h0000_0108, 32'h0000_0100};
        tbl[9]  = '{1'b1, 4'd15, 32'hFFFF_FFFC, 4'd15, 1'b0, 32'h0000_0004, 32'h0000_0100};
        tbl[10] = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b1, 32'h0000_0004, 32'hFFFF_FFFC};
        tbl[11] = '{1'b0, 4'd0,  32'h0,         4'd15, 1'b0, 32'd8,         32'h0};
        tbl[12] = '{1'b1, 4'd0,  32'h0000_A5A5, 4'd0,  1'b0, 32'h0000_A5A5, 32'h0};
        tbl[13] = '{1'b0, 4'd0,  32'h0,         4'd0,  1'b0, 32'h0000_A5A5, 32'h0};
        tbl[14] = '{1'b1, 4'd13, 32'h0000_5555, 4'd13, 1'b0, 32'h0000_5555, 32'h0};
        tbl[15] = '{1'b0, 4'd0,  32'h0,         4'd13, 1'b0, 32'h0000_5555, 32'h0};
        tbl[16] = '{1'b1, 4'd11, 32'h0001_FFFE, 4'd11, 1'b0, 32'h0001_FFFE, 32'h0};
        tbl[17] = '{1'b0, 4'd0,  32'h0,         4'd11, 1'b1, 32'h0001_FFFE, 32'h0};
        tbl[18] = '{1'b0, 4'd0,  32'h0,         4'd11, 1'b0, 32'h0001_FFFE, 32'd4};
    end

    // ---------------------------------------------------------------- test
    initial begin
        reset = 1'b0; we = 1'b0; wa = '0; wd = '0; a = '0; b = '0; d = '0; pc_inc = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Dirty some state, then assert reset mid-cycle with a write pending.
        apply(1'b1, 4'd3, 32'h77, 4'd3, 4'd3, 4'd3, 1'b1, "pre");
        apply(1'b0, 4'd0, 32'h0,  4'd3, 4'd15, 4'd0, 1'b1, "pre");
        we = 1'b1; wa = 4'd3; wd = 32'd5; a = 4'd15; b = 4'd15; d = 4'd15; pc_inc = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async rst pc_out", pc0, 32'h0);
        chk("async rst pa(15)", pa0, 32'd8);
        check_all("async rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        // R3 must still be zero: the write during reset was dropped.
        apply(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd3, 1'b0, "post rst");
        chk("post rst r3", pa0, 32'h0);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            a = tbl[i].a; b = tbl[i].a; d = ~tbl[i].a; pc_inc = tbl[i].inc;
            #4;
            chk($sformatf("tbl%0d pa", i), pa0, tbl[i].exp_pa);
            chk($sformatf("tbl%0d pc_out", i), pc0, tbl[i].exp_pc);
            check_all($sformatf("tbl%0d", i));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rwd;
            rwd = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rwd,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
